fix2flt_seq: RTL and testbench
==============================

Name: fix2flt_seq

Overview:
Sequential fixed 8.8 to IEEE-754 half-precision converter. It is the reverse-direction companion of the float-to-fixed converter and uses the same start/done handshake with the test bench.
- Reads a two's-complement 8.8 value from data memory, two bytes.
- Normalizes it iteratively, one shift per cycle.
- Rounds to nearest-even and writes the 16-bit float back to data memory.

Parameters:
SRC_LO, 8'd0, data-memory address of input low byte (fraction bits)
SRC_HI, 8'd1, data-memory address of input high byte (integer bits, sign in bit 7)
DST_LO, 8'd2, address of output float low byte
DST_HI, 8'd3, address of output float high byte

Ports:
clk       input   1  single clock; all state changes on posedge
reset     input   1  synchronous, active-high
start     input   1  request from test bench; job launches on its falling edge
dm_rdata  input   8  data-memory read data (asynchronous read, valid in the same cycle as dm_addr)
dm_addr   output  8  data-memory address
dm_we     output  1  data-memory write enable
dm_wdata  output  8  data-memory write data
done      output  1  one-cycle acknowledge pulse to test bench

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: done=0, dm_we=0, dm_addr=0, dm_wdata=0, state=IDLE, start_q=0.
- start_q is start registered each cycle. Launch condition is start_q && !start, evaluated only in IDLE.
- FSM states and actions:
  - IDLE: wait for the launch condition, then go to RD_LO.
  - RD_LO: dm_addr=SRC_LO; capture x[7:0].
  - RD_HI: dm_addr=SRC_HI; capture x[15:8].
  - ABS: sign=x[15]; mag = sign ? (~x+1) : x, as 16-bit unsigned (0x8000 gives mag 0x8000). If mag==0, set result=16'h0000 and go to WR_LO; otherwise clear k and go to NORM.
  - NORM: while !mag[15], shift mag left 1 and k++. Go to ROUND when mag[15]=1. Occupies k+1 cycles, k in 0..15.
  - ROUND: e = 22-k (5 bits, range 7..22); m = mag[14:5]; guard = mag[4]; sticky = |mag[3:0].
    - Round up when guard && (sticky || m[0]).
    - If m overflows from 0x3FF: m=0, e=e+1.
    - result = {sign, e, m}. Output is always normal: no subnormals, inf or NaN.
  - WR_LO: dm_addr=DST_LO, dm_we=1, dm_wdata=result[7:0].
  - WR_HI: dm_addr=DST_HI, dm_we=1, dm_wdata=result[15:8].
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- dm_we is high only in WR_LO and WR_HI.
- Latency, counting cycles after the IDLE cycle that sees the launch condition:
  - nonzero input: done high in cycle k+8;
  - zero input: done high in cycle 6.
- start activity outside IDLE is ignored; a falling edge that occurs mid-job does not queue a second job.
- Reset mid-job: next state IDLE and done=0 immediately; no further memory writes. A partially written destination is left as-is.
- Back-to-back jobs: a new falling edge may be detected starting the cycle after DONE.

Decomposition:
- Package fix2flt_pkg:
  - state enum (IDLE, RD_LO, RD_HI, ABS, NORM, ROUND, WR_LO, WR_HI, DONE);
  - constants EXP_BIAS=15, FRAC_BITS=8, MANT_BITS=10.
- Sub-module fix2flt_round: combinational, takes (sign, normalized mag[15:0], k[3:0]) and returns the packed float[15:0]. Instantiated once, consumed in ROUND.

Test Plan:
- mem[0..1]=0x0100 (1.0), pulse start -> mem[2..3]=0x3C00; k=7, done in cycle 15.
- 0xFF00 (-1.0) -> 0xBC00. 0x8000 (-128.0) -> 0xD800 (max negative, no overflow).
- 0x0000 -> 0x0000, done in cycle 6. 0x0001 (2^-8) -> 0x1C00, done in cycle 23 (max latency).
- Rounding:
  - 0x7FFF -> 0x5800 (round-up carries into exponent, 128.0);
  - 0x4008 -> 0x5400 (exact tie, rounds to even, 64.0);
  - 0x0FFF -> 0x4C00.
- Assert reset during NORM for 0x0001 -> done stays 0, dm_we never rises, mem[2..3] unchanged. The next start pulse converts correctly.
- Raise start again while in NORM -> ignored, exactly one done pulse. Two jobs issued back-to-back with no gap both complete.

Source files
------------

// File: rtl/fix2flt_pkg.sv
// Shared types and constants for the sequential 8.8 fixed-point to half-precision converter.
package fix2flt_pkg;

   typedef enum logic [3:0] {
      IDLE,
      RD_LO,
      RD_HI,
      ABS,
      NORM,
      ROUND,
      WR_LO,
      WR_HI,
      DONE
   } state_t;

   localparam int EXP_BIAS  = 15;
   localparam int FRAC_BITS = 8;
   localparam int MANT_BITS = 10;

endpackage

// File: rtl/fix2flt_seq_if.sv
// Start/done handshake plus data-memory port between the converter and its host.
interface fix2flt_seq_if;

   logic       start;
   logic       done;
   logic [7:0] dm_rdata;
   logic [7:0] dm_addr;
   logic       dm_we;
   logic [7:0] dm_wdata;

   modport master (
      output start,
      output dm_rdata,
      input  done,
      input  dm_addr,
      input  dm_we,
      input  dm_wdata
   );

   modport slave (
      input  start,
      input  dm_rdata,
      output done,
      output dm_addr,
      output dm_we,
      output dm_wdata
   );

endinterface

// File: rtl/fix2flt_round.sv
// Packs a normalized magnitude into a half-precision float, rounding to nearest-even.
module fix2flt_round
   import fix2flt_pkg::*;
(
   input  logic        sign,
   input  logic [15:0] mag,
   input  logic [3:0]  k,
   output logic [15:0] flt
);

   // Exponent when mag[15] was already set in the fixed-point input (no shifts).
   localparam logic [4:0] E_TOP = 5'(EXP_BIAS + 15 - FRAC_BITS);

   function automatic logic [15:0] round_pack(input logic        s,
                                              input logic [15:0] mg,
                                              input logic [3:0]  sh);
      logic [MANT_BITS-1:0] m;
      logic                 guard;
      logic                 sticky;
      logic                 rnd_up;
      logic [MANT_BITS:0]   m_sum;
      logic [4:0]           e;
      m      = mg[14 -: MANT_BITS];
      guard  = mg[4];
      sticky = |mg[3:0];
      rnd_up = guard & (sticky | m[0]);
      m_sum  = {1'b0, m} + {{MANT_BITS{1'b0}}, rnd_up};
      e      = E_TOP - {1'b0, sh};
      // A carry out of the mantissa leaves it zero and bumps the exponent.
      if (m_sum[MANT_BITS]) e = e + 5'd1;
      return {s, e, m_sum[MANT_BITS-1:0]};
   endfunction

   assign flt = round_pack(sign, mag, k);

endmodule

// File: rtl/fix2flt_seq.sv
// Sequential 8.8 two's-complement to IEEE-754 half converter driven by a start/done handshake.
module fix2flt_seq
   import fix2flt_pkg::*;
#(
   parameter logic [7:0] SRC_LO = 8'd0,
   parameter logic [7:0] SRC_HI = 8'd1,
   parameter logic [7:0] DST_LO = 8'd2,
   parameter logic [7:0] DST_HI = 8'd3
) (
   input  logic         clk,
   input  logic         reset,
   fix2flt_seq_if.slave bus
);

   state_t             state;
   logic               start_q;
   logic signed [15:0] x;
   logic               sign;
   logic [15:0]        mag;
   logic [3:0]         k;
   logic [15:0]        result;
   logic [15:0]        rnd_flt;

   fix2flt_round u_round (
      .sign (sign),
      .mag  (mag),
      .k    (k),
      .flt  (rnd_flt)
   );

   // Outputs are registered from the next state, so dm_addr is already valid
   // during the read states and the asynchronous memory answers in that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         start_q      <= 1'b0;
         bus.done     <= 1'b0;
         bus.dm_we    <= 1'b0;
         bus.dm_addr  <= 8'd0;
         bus.dm_wdata <= 8'd0;
      end else begin
         start_q   <= bus.start;
         bus.done  <= 1'b0;
         bus.dm_we <= 1'b0;
         case (state)
            IDLE: begin
               if (start_q && !bus.start) begin
                  bus.dm_addr <= SRC_LO;
                  state       <= RD_LO;
               end
            end
            RD_LO: begin
               x[7:0]      <= bus.dm_rdata;
               bus.dm_addr <= SRC_HI;
               state       <= RD_HI;
            end
            RD_HI: begin
               x[15:8] <= bus.dm_rdata;
               state   <= ABS;
            end
            ABS: begin
               sign <= x[15];
               // -0x8000 wraps back to 0x8000, which is the correct unsigned magnitude.
               mag  <= x[15] ? $unsigned(-x) : $unsigned(x);
               k    <= 4'd0;
               if (x == 16'sd0) begin
                  result       <= 16'h0000;
                  bus.dm_wdata <= 8'h00;
                  bus.dm_addr  <= DST_LO;
                  bus.dm_we    <= 1'b1;
                  state        <= WR_LO;
               end else begin
                  state <= NORM;
               end
            end
            NORM: begin
               if (mag[15]) begin
                  state <= ROUND;
               end else begin
                  mag <= {mag[14:0], 1'b0};
                  k   <= k + 4'd1;
               end
            end
            ROUND: begin
               result       <= rnd_flt;
               bus.dm_wdata <= rnd_flt[7:0];
               bus.dm_addr  <= DST_LO;
               bus.dm_we    <= 1'b1;
               state        <= WR_LO;
            end
            WR_LO: begin
               bus.dm_wdata <= result[15:8];
               bus.dm_addr  <= DST_HI;
               bus.dm_we    <= 1'b1;
               state        <= WR_HI;
            end
            WR_HI: begin
               bus.done <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fix2flt_seq.sv
// Bench for fix2flt_seq: directed vectors, random vectors vs. an arithmetic model, and handshake corners.
module tb_fix2flt_seq;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fix2flt_seq_if bus ();

   fix2flt_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   logic [7:0] mem [256];
   logic       pl_we = 1'b0;
   logic [7:0] pl_addr = 8'd0;
   logic [7:0] pl_data = 8'd0;
   int         done_cnt = 0;
   int         we_cnt = 0;
   int         n_cmp = 0;
   int         n_fail = 0;

   assign bus.dm_rdata = mem[bus.dm_addr];

   always @(posedge clk) begin
      if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_wdata;
      else if (pl_we) mem[pl_addr] <= pl_data;
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.dm_we) we_cnt <= we_cnt + 1;
   end

   typedef struct {
      logic [15:0] x;
      logic [15:0] f;
      int          lat;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: real-valued conversion of x/256, expressed with integer arithmetic.
   function automatic logic [15:0] ref_flt(input logic [15:0] v);
      int s, mg, p, q, fr, rem, e;
      s  = int'(v[15]);
      mg = (s == 1) ? 65536 - int'(v) : int'(v);
      if (mg == 0) return 16'h0000;
      p = 0;
      for (int i = 0; i < 16; i++) if (mg >= (1 << i)) p = i;
      q   = mg << 10;
      fr  = q >> p;
      rem = q - (fr << p);
      if ((2 * rem > (1 << p)) || ((2 * rem == (1 << p)) && (fr % 2 == 1))) fr++;
      e = p - 8 + 15;
      if (fr == 2048) begin
         fr = 1024;
         e++;
      end
      return 16'((s << 15) | (e << 10) | (fr - 1024));
   endfunction

   function automatic int ref_lat(input logic [15:0] v);
      int mg, p;
      mg = v[15] ? 65536 - int'(v) : int'(v);
      if (mg == 0) return 6;
      p = 0;
      for (int i = 0; i < 16; i++) if (mg >= (1 << i)) p = i;
      return (15 - p) + 8;
   endfunction

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_addr = a;
      pl_data = d;
      pl_we   = 1'b1;
      @(negedge clk);
      pl_we   = 1'b0;
   endtask

   task automatic load(input logic [15:0] x);
      poke(8'd0, x[7:0]);
      poke(8'd1, x[15:8]);
      poke(8'd2, 8'h5A);
      poke(8'd3, 8'hA5);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Counts cycles after the launch cycle until done is seen; bounded.
   task automatic wait_done(output int lat);
      lat = 0;
      forever begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.done === 1'b1) break;
         if (lat >= 200) begin
            chk("done_timeout", 32'(lat), 32'd0);
            break;
         end
      end
   endtask

   task automatic run_job(input logic [15:0] x, output logic [15:0] f, output int lat);
      load(x);
      pulse_start();
      wait_done(lat);
      f = {mem[3], mem[2]};
   endtask

   initial begin
      logic [15:0] f;
      logic [15:0] xr;
      int          lat;
      int          dc;
      int          wc;

      tbl[0] = '{16'h0100, 16'h3C00, 15};
      tbl[1] = '{16'hFF00, 16'hBC00, 15};
      tbl[2] = '{16'h8000, 16'hD800, 8};
      tbl[3] = '{16'h0000, 16'h0000, 6};
      tbl[4] = '{16'h0001, 16'h1C00, 23};
      tbl[5] = '{16'h7FFF, 16'h5800, 9};
      tbl[6] = '{16'h4008, 16'h5400, 9};
      tbl[7] = '{16'h0FFF, 16'h4C00, 12};
      tbl[8] = '{16'hFFFF, 16'h9C00, 23};

      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_we", 32'(bus.dm_we), 32'd0);
      chk("rst_addr", 32'(bus.dm_addr), 32'd0);
      chk("rst_wdata", 32'(bus.dm_wdata), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_job(tbl[i].x, f, lat);
         chk($sformatf("vec%0d_result", i), 32'(f), 32'(tbl[i].f));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
      end

      for (int i = 0; i < 40; i++) begin
         xr = 16'($urandom);
         run_job(xr, f, lat);
         chk($sformatf("rand_result_x%04h", xr), 32'(f), 32'(ref_flt(xr)));
         chk($sformatf("rand_latency_x%04h", xr), 32'(lat), 32'(ref_lat(xr)));
      end

      // Reset while normalizing: no writes, no done, destination untouched.
      load(16'h0001);
      pulse_start();
      dc = done_cnt;
      wc = we_cnt;
      repeat (8) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("rst_mid_done", 32'(done_cnt), 32'(dc));
      chk("rst_mid_we", 32'(we_cnt), 32'(wc));
      chk("rst_mid_dst", 32'({mem[3], mem[2]}), 32'h0000_A55A);
      run_job(16'h0001, f, lat);
      chk("after_rst_result", 32'(f), 32'h1C00);
      chk("after_rst_latency", 32'(lat), 32'd23);

      // Falling start edge during NORM is ignored.
      load(16'h0001);
      pulse_start();
      dc = done_cnt;
      repeat (6) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat);
      chk("ignore_latency", 32'(lat + 7), 32'd23);
      chk("ignore_result", 32'({mem[3], mem[2]}), 32'h1C00);
      repeat (40) @(negedge clk);
      chk("ignore_done_count", 32'(done_cnt), 32'(dc + 1));

      // Back-to-back: start held high across DONE, released in the following IDLE cycle.
      load(16'h0100);
      pulse_start();
      dc = done_cnt;
      repeat (14) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("b2b_first_done", 32'(bus.done), 32'd1);
      chk("b2b_first_result", 32'({mem[3], mem[2]}), 32'h3C00);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat);
      chk("b2b_second_latency", 32'(lat), 32'd15);
      repeat (40) @(negedge clk);
      chk("b2b_done_count", 32'(done_cnt), 32'(dc + 2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
